// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the pipelined RV32I core.
// Issues word-addressed req/ack bus accesses with byte enables. Replicates store
// data across byte lanes and extends load data. Stalls the pipeline while an
// access is outstanding, and flags misaligned accesses and bus timeouts.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] read_data_q, read_data_d;
  logic        bus_err_q, bus_err_d;

  logic        access, is_store, is_load;
  logic        size_byte, size_half, size_word;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        req, ack_taken, timeout;

  // Decode the access kind and size; a store wins if both store and load are flagged.
  always_comb begin
    access    = MemWriteM | (ResultSrcM == 2'b01);
    is_store  = MemWriteM;
    is_load   = ~MemWriteM & (ResultSrcM == 2'b01);
    size_byte = (Funct3M[1:0] == 2'b00);
    size_half = (Funct3M[1:0] == 2'b01);
    size_word = ~size_byte & ~size_half;
    misalign  = access & ((size_half & ALUResultM[0]) |
                          (size_word & (ALUResultM[1:0] != 2'b00)));
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    if (size_byte) begin
      be    = 4'b0001 << ALUResultM[1:0];
      wdata = {4{WriteDataM[7:0]}};
    end else if (size_half) begin
      be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
      wdata = {2{WriteDataM[15:0]}};
    end
  end

  // Select the addressed lane of the read word and sign/zero-extend it.
  always_comb begin
    byte_sel = 8'h00;
    case (ALUResultM[1:0])
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (Funct3M)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Access FSM: request, wait for ack or timeout, then one DONE cycle for the pipeline to advance.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    read_data_d = read_data_q;
    bus_err_d   = bus_err_q;
    req         = 1'b0;
    ack_taken   = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misalign) begin
          req = 1'b1;
          if (mem_ack) begin
            ack_taken = 1'b1;
            state_d   = DONE;
          end else begin
            state_d    = BUSY;
            wait_cnt_d = 16'd0;
          end
        end
      end
      BUSY: begin
        req = 1'b1;
        if (mem_ack) begin
          ack_taken = 1'b1;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          if (wait_cnt_q + 16'd1 == MAX_WAIT_C) begin
            timeout = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ack_taken && is_load) read_data_d = load_ext;
    if (timeout) begin
      bus_err_d = 1'b1;
      if (is_load) read_data_d = 32'h0;
    end
  end

  // State, wait counter, load result and sticky bus error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 16'd0;
      read_data_q <= 32'h0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = req;
  assign StallM    = req;
  assign mem_we    = req & is_store;
  assign mem_addr  = req ? {ALUResultM[31:2], 2'b00} : 32'h0;
  assign mem_be    = req ? be : 4'b0000;
  assign mem_wdata = req ? wdata : 32'h0;
  assign MisalignM = (state_q == IDLE) & misalign;
  assign ReadDataM = read_data_q;
  assign BusErrM   = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu with a short bus timeout (MAX_WAIT = 4).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;
  logic        BusErrM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;
  int stalls;

  mem_stage_lsu #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd);
    MemWriteM  = we;
    ResultSrcM = rs;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    mem_rdata  = rd;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    mem_ack = 1'b0;
  endtask

  // Runs an already-presented access; ack rises in cycle ack_at (0 = issue cycle,
  // k = k-th BUSY cycle). Returns with the bench sitting in the first non-stalled cycle.
  task automatic run_access(input int ack_at, output int n_stall);
    n_stall = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ack = (c == ack_at);
      #1;
      if (!StallM) break;
      n_stall++;
      next_cycle();
    end
    mem_ack = 1'b0;
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp);
    int n;
    next_cycle();
    apply_stimulus(1'b0, 2'b01, f3, addr, 32'h0, rd);
    run_access(0, n);
    check_output({tag, "_stall"}, n, 1);
    check_output({tag, "_data"}, ReadDataM, exp);
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    check_output("rst_req", mem_req, 0);
    check_output("rst_stall", StallM, 0);
    check_output("rst_rdata", ReadDataM, 0);
    check_output("rst_buserr", BusErrM, 0);
    check_output("rst_be", mem_be, 0);
    check_output("rst_we", mem_we, 0);
    check_output("rst_misalign", MisalignM, 0);
    next_cycle();
    reset = 1'b0;

    // LW with a zero-wait bus
    next_cycle();
    apply_stimulus(1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF);
    mem_ack = 1'b0;
    #1;
    check_output("lw_req", mem_req, 1);
    check_output("lw_be", mem_be, 4'b1111);
    check_output("lw_addr", mem_addr, 32'h100);
    check_output("lw_we", mem_we, 0);
    run_access(0, stalls);
    check_output("lw_stall", stalls, 1);
    check_output("lw_data", ReadDataM, 32'hDEADBEEF);
    check_output("lw_done_req", mem_req, 0);
    check_output("lw_done_be", mem_be, 0);
    next_cycle();
    idle_inputs();

    // Sub-word loads from the same word
    do_load("lb", 3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
    do_load("lh", 3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
    do_load("lb0", 3'b000, 32'h100, 32'h80112233, 32'h00000033);
    do_load("lhu", 3'b101, 32'h102, 32'h80112233, 32'h00008011);

    // SB with ack in the third BUSY cycle
    next_cycle();
    apply_stimulus(1'b1, 2'b00, 3'b000, 32'h201, 32'h000000A5, 32'h0);
    mem_ack = 1'b0;
    #1;
    check_output("sb_we", mem_we, 1);
    check_output("sb_be", mem_be, 4'b0010);
    check_output("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    check_output("sb_addr", mem_addr, 32'h200);
    run_access(3, stalls);
    check_output("sb_stall", stalls, 4);
    check_output("sb_rdata_hold", ReadDataM, 32'h00008011);
    next_cycle();
    idle_inputs();

    // SH upper half
    next_cycle();
    apply_stimulus(1'b1, 2'b00, 3'b001, 32'h206, 32'h1234BEEF, 32'h0);
    mem_ack = 1'b0;
    #1;
    check_output("sh_be", mem_be, 4'b1100);
    check_output("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    run_access(0, stalls);
    check_output("sh_stall", stalls, 1);
    next_cycle();
    idle_inputs();

    // Misaligned SW and LH
    next_cycle();
    apply_stimulus(1'b1, 2'b00, 3'b010, 32'h202, 32'hFFFFFFFF, 32'h0);
    #1;
    check_output("sw_mis_flag", MisalignM, 1);
    check_output("sw_mis_req", mem_req, 0);
    check_output("sw_mis_stall", StallM, 0);
    next_cycle();
    apply_stimulus(1'b0, 2'b01, 3'b001, 32'h301, 32'h0, 32'hCAFEF00D);
    mem_ack = 1'b1;
    #1;
    check_output("lh_mis_flag", MisalignM, 1);
    check_output("lh_mis_req", mem_req, 0);
    check_output("lh_mis_stall", StallM, 0);
    next_cycle();
    idle_inputs();
    #1;
    check_output("mis_clear", MisalignM, 0);
    check_output("lh_mis_rdata", ReadDataM, 32'h00008011);

    // LW timeout with no ack
    next_cycle();
    apply_stimulus(1'b0, 2'b01, 3'b010, 32'h500, 32'h0, 32'h55555555);
    run_access(99, stalls);
    check_output("to_stall", stalls, 5);
    check_output("to_rdata", ReadDataM, 0);
    check_output("to_buserr", BusErrM, 1);
    next_cycle();
    idle_inputs();

    // Later access: bus error remains sticky
    next_cycle();
    apply_stimulus(1'b0, 2'b01, 3'b010, 32'h104, 32'h0, 32'h0BADF00D);
    run_access(2, stalls);
    check_output("post_to_stall", stalls, 3);
    check_output("post_to_rdata", ReadDataM, 32'h0BADF00D);
    check_output("post_to_buserr", BusErrM, 1);
    next_cycle();
    idle_inputs();

    // Reset asserted while BUSY
    next_cycle();
    apply_stimulus(1'b0, 2'b01, 3'b010, 32'h400, 32'h0, 32'h0);
    mem_ack = 1'b0;
    next_cycle();
    check_output("busy_stall", StallM, 1);
    reset = 1'b1;
    idle_inputs();
    #1;
    check_output("mid_rst_req", mem_req, 0);
    check_output("mid_rst_stall", StallM, 0);
    check_output("mid_rst_rdata", ReadDataM, 0);
    check_output("mid_rst_buserr", BusErrM, 0);
    next_cycle();
    reset = 1'b0;

    // Normal LW after reset
    next_cycle();
    apply_stimulus(1'b0, 2'b01, 3'b010, 32'h108, 32'h0, 32'h12345678);
    run_access(1, stalls);
    check_output("after_rst_stall", stalls, 2);
    check_output("after_rst_rdata", ReadDataM, 32'h12345678);
    check_output("after_rst_buserr", BusErrM, 0);
    next_cycle();
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the pipelined RV32I core; consumes the registered EX/MEM outputs.
- Drives a word-addressed req/ack data-memory bus with byte enables, aligns store data, and sign/zero-extends load data.
- Stalls the pipeline while a bus access is outstanding, and detects misaligned accesses and bus timeouts.

Parameters:
- MAX_WAIT, 255: maximum BUSY cycles without mem_ack before the access is abandoned as a bus error (1..65535).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- MemWriteM  in  1  store in MEM stage
- ResultSrcM  in  2  2'b01 = load in MEM stage
- Funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data (rs2)
- StallM  out  1  freeze IF/ID/EX and EX/MEM registers
- ReadDataM  out  32  aligned, extended load result (registered)
- MisalignM  out  1  one-cycle flag: misaligned access suppressed
- BusErrM  out  1  sticky timeout flag
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  {ALUResultM[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when mem_ack = 1
- mem_ack  in  1  access complete this cycle

Behaviour:
- Decoding: access = MemWriteM | (ResultSrcM == 2'b01). MemWriteM has priority if both are set.
- Unlisted Funct3M codes (011/110/111) are treated as a word access.
- Misalignment: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - No bus request, no stall; MisalignM = 1 combinationally for that cycle.
  - ReadDataM is unchanged.
- Byte enables:
  - Byte: mem_be = 4'b0001 << addr[1:0].
  - Halfword: mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: mem_be = 4'b1111.
- Store data: byte = {4{wd[7:0]}}, half = {2{wd[15:0]}}, word = wd.
- Load data: select the lane addressed by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes the word through.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, no access or misaligned: stay IDLE; mem_req = 0, StallM = 0.
  - IDLE, aligned access: mem_req = 1 and StallM = 1 combinationally. mem_ack = 1 goes to DONE; otherwise go to BUSY and clear the wait counter.
  - BUSY: mem_req = 1, StallM = 1; bus fields are driven from the M inputs, which stay stable because of the stall.
    - mem_ack = 1 goes to DONE.
    - Otherwise the counter increments. When the counter reaches MAX_WAIT, go to DONE with BusErrM set to 1.
  - DONE: mem_req = 0, StallM = 0. The pipeline advances at the end of this cycle. Next state is IDLE, and the next access cannot issue before the following cycle.
- ReadDataM capture:
  - Load ack: ReadDataM is loaded with the extended data on the ack edge, so it is valid in DONE.
  - Load timeout: ReadDataM is loaded with 0.
  - Otherwise ReadDataM holds its last value.
- Latency: a zero-wait bus gives 1 stall cycle plus the DONE cycle. An ack after N BUSY cycles gives N+1 stall cycles.
- mem_ack outside IDLE-with-access or BUSY is ignored.
- BusErrM stays 1 until reset.
- Reset values (any time, including mid-access): state IDLE, counter 0, ReadDataM 0, BusErrM 0. Hence mem_req 0, StallM 0, mem_we 0, mem_be 0, MisalignM 0 while no access is presented.
- Bus fields are 0 whenever mem_req = 0.

Test Plan:
- LW addr 0x100, mem_ack in the same cycle, rdata 0xDEADBEEF -> StallM high 1 cycle, mem_be 4'b1111, ReadDataM = 0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80112233 -> ReadDataM = 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- SB addr 0x201, wd 0x000000A5, ack after 3 BUSY cycles -> mem_we 1, mem_be 4'b0010, mem_wdata 0xA5A5A5A5, StallM high 4 cycles.
- SW addr 0x202 -> MisalignM = 1 for 1 cycle, mem_req 0, StallM 0. LH addr 0x301 -> same response, ReadDataM unchanged.
- MAX_WAIT = 4, LW with no ack -> StallM high 5 cycles, then DONE with ReadDataM = 0, and BusErrM stays 1 through later accesses until reset.
- Assert reset during BUSY -> mem_req/StallM/ReadDataM/BusErrM go 0 immediately. After release, a new LW completes normally.
